debug_fifo_wr_arbiter: RTL and testbench

- Write-side scheduler for the debug capture FIFO (64-bit write port, full/prog_full flags, read back by the host as 32-bit words).
- Shares the single FIFO write port between N_SRC on-chip debug sources using round-robin, burst-granular arbitration.
- Closes every burst with a 64-bit trailer word so the host can demultiplex the stream.
- Sits in the wr_clk domain, directly in front of the FIFO write port.

---
 rtl/debug_arb_pkg.sv | 33 +++
 rtl/rr_pick.sv | 34 +++
 rtl/debug_fifo_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_debug_fifo_wr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_arb_pkg.sv
// Shared state encoding and trailer layout for the debug FIFO write arbiters.
package debug_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_TRAIL = 2'd2
   } arb_state_e;

   localparam logic [15:0] HDR_MAGIC_DEF = 16'hDB60;

   localparam int TRL_MAGIC_LSB = 48;
   localparam int TRL_GRANT_LSB = 40;
   localparam int TRL_CNT_LSB   = 32;
   localparam int TRL_SEQ_LSB   = 0;

   // Bits [47:44] stay zero so the host can widen the grant field later.
   function automatic logic [63:0] build_trailer(
      input logic [15:0] magic,
      input logic [3:0]  grant,
      input logic [7:0]  cnt,
      input logic [31:0] seq
   );
      logic [63:0] t;
      t = 64'd0;
      t[TRL_MAGIC_LSB +: 16] = magic;
      t[TRL_GRANT_LSB +: 4]  = grant;
      t[TRL_CNT_LSB +: 8]    = cnt;
      t[TRL_SEQ_LSB +: 32]   = seq;
      return t;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping at N.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   input  logic [3:0]   ptr_i,
   output logic [3:0]   idx_o,
   output logic         any_o
);

   logic [15:0] req_ext_s;
   logic [4:0]  sum_s;
   logic [4:0]  pos_s;
   logic        hit_s;

   assign req_ext_s = 16'(req_i);

   // Cyclic scan from the pointer; the first hit wins.
   always_comb begin
      idx_o = 4'd0;
      any_o = 1'b0;
      sum_s = 5'd0;
      pos_s = 5'd0;
      hit_s = 1'b0;
      for (int k = 0; k < N; k++) begin
         sum_s = 5'(ptr_i) + 5'(k);
         pos_s = (sum_s >= 5'(N)) ? (sum_s - 5'(N)) : sum_s;
         hit_s = !any_o && req_ext_s[pos_s[3:0]];
         any_o = any_o | hit_s;
         idx_o = hit_s ? pos_s[3:0] : idx_o;
      end
   end

endmodule

// File: rtl/debug_fifo_wr_arbiter.sv
// Round-robin, burst-granular scheduler for the debug capture FIFO write port;
// every burst is closed by a trailer word carrying source, length and sequence number.
module debug_fifo_wr_arbiter
   import debug_arb_pkg::*;
#(
   parameter int          N_SRC     = 4,
   parameter int          BURST_LEN = 16,
   parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
   input  logic                  wr_clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic [N_SRC-1:0]      src_valid,
   input  logic [N_SRC*64-1:0]   src_data,
   output logic [N_SRC-1:0]      src_ready,
   output logic [63:0]           fifo_din,
   output logic                  fifo_wr_en,
   input  logic                  fifo_full,
   input  logic                  fifo_prog_full,
   output logic                  busy,
   output logic [3:0]            grant_id,
   output logic [31:0]           seq_num
);

   arb_state_e  state_q, state_d;
   logic [3:0]  rr_ptr_q, rr_ptr_d;
   logic [3:0]  grant_q, grant_d;
   logic [7:0]  word_cnt_q, word_cnt_d;
   logic [31:0] seq_q, seq_d;

   logic [3:0]  pick_idx_s;
   logic        pick_any_s;
   logic        gnt_valid_s;
   logic [63:0] gnt_data_s;
   logic        room_s;
   logic        xfer_s;
   logic        last_s;

   rr_pick #(.N(N_SRC)) u_pick (
      .req_i (src_valid),
      .ptr_i (rr_ptr_q),
      .idx_o (pick_idx_s),
      .any_o (pick_any_s)
   );

   // Select the granted source's valid and data.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_data_s  = 64'd0;
      for (int i = 0; i < N_SRC; i++) begin
         gnt_valid_s = (grant_q == 4'(i)) ? src_valid[i] : gnt_valid_s;
         gnt_data_s  = (grant_q == 4'(i)) ? src_data[64*i +: 64] : gnt_data_s;
      end
   end

   assign room_s = !fifo_full && (word_cnt_q < 8'(BURST_LEN));
   assign xfer_s = (state_q == ST_DATA) && gnt_valid_s && room_s;
   assign last_s = ((word_cnt_q + 8'd1) == 8'(BURST_LEN));

   // FIFO write port and source handshakes; data passes straight through.
   always_comb begin
      src_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = 64'd0;
      case (state_q)
         ST_DATA: begin
            for (int i = 0; i < N_SRC; i++) begin
               src_ready[i] = (grant_q == 4'(i)) && room_s;
            end
            fifo_wr_en = xfer_s;
            fifo_din   = xfer_s ? gnt_data_s : 64'd0;
         end
         ST_TRAIL: begin
            fifo_wr_en = !fifo_full;
            fifo_din   = !fifo_full ? build_trailer(HDR_MAGIC, grant_q, word_cnt_q, seq_q) : 64'd0;
         end
         default: begin
            src_ready  = '0;
            fifo_wr_en = 1'b0;
            fifo_din   = 64'd0;
         end
      endcase
   end

   // Burst sequencing: a gap or a full burst ends DATA; the trailer waits out fifo_full.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      word_cnt_d = word_cnt_q;
      seq_d      = seq_q;
      case (state_q)
         ST_IDLE: begin
            if (en && !fifo_prog_full && pick_any_s) begin
               state_d    = ST_DATA;
               grant_d    = pick_idx_s;
               word_cnt_d = 8'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (xfer_s) begin
               word_cnt_d = word_cnt_q + 8'd1;
               state_d    = last_s ? ST_TRAIL : ST_DATA;
            end else if (!gnt_valid_s) begin
               state_d = ST_TRAIL;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_TRAIL: begin
            if (!fifo_full) begin
               seq_d    = seq_q + 32'd1;
               rr_ptr_d = (grant_q == 4'(N_SRC-1)) ? 4'd0 : (grant_q + 4'd1);
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_TRAIL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge wr_clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= 4'd0;
         grant_q    <= 4'd0;
         word_cnt_q <= 8'd0;
         seq_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         word_cnt_q <= word_cnt_d;
         seq_q      <= seq_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign grant_id = busy ? grant_q : 4'd0;
   assign seq_num  = seq_q;

endmodule

// File: tb/tb_debug_fifo_wr_arbiter.sv
// Directed bench for debug_fifo_wr_arbiter: a per-cycle vector table plus
// multi-cycle sequences for burst cap, fairness, backpressure, gating and reset.
module tb_debug_fifo_wr_arbiter;

   localparam int N = 4;

   localparam logic [63:0] W_A = 64'hAAAA_0000_0000_0001;
   localparam logic [63:0] W_B = 64'hBBBB_0000_0000_0002;
   localparam logic [63:0] W_C = 64'hCCCC_0000_0000_0003;
   localparam logic [63:0] W_D = 64'hDDDD_0000_0000_0004;
   localparam logic [63:0] T_1 = 64'hDB60_0003_0000_0000;
   localparam logic [63:0] T_2 = 64'hDB60_0001_0000_0001;

   logic            wr_clk = 1'b0;
   logic            rstn;
   logic            en;
   logic [N-1:0]    src_valid;
   logic [N*64-1:0] src_data;
   logic [N-1:0]    src_ready;
   logic [63:0]     fifo_din;
   logic            fifo_wr_en;
   logic            fifo_full;
   logic            fifo_prog_full;
   logic            busy;
   logic [3:0]      grant_id;
   logic [31:0]     seq_num;

   int n_checks = 0;
   int n_err    = 0;
   int src_left[N];
   int src_sent[N];
   logic [63:0] wr_log[$];
   logic [63:0] exp_q[$];
   logic smp_busy;

   typedef struct {
      logic        en;
      logic        pf;
      logic        full;
      logic        v0;
      logic [63:0] d0;
      logic        we;
      logic [63:0] din;
      logic [3:0]  rdy;
      logic        busy;
      logic [31:0] seq;
   } vec_t;

   vec_t vt[16];

   always #5 wr_clk = ~wr_clk;

   debug_fifo_wr_arbiter dut (
      .wr_clk         (wr_clk),
      .rstn           (rstn),
      .en             (en),
      .src_valid      (src_valid),
      .src_data       (src_data),
      .src_ready      (src_ready),
      .fifo_din       (fifo_din),
      .fifo_wr_en     (fifo_wr_en),
      .fifo_full      (fifo_full),
      .fifo_prog_full (fifo_prog_full),
      .busy           (busy),
      .grant_id       (grant_id),
      .seq_num        (seq_num)
   );

   function automatic logic [63:0] mk_word(input int i, input int k);
      return {8'(i + 1), 24'h5A5A5A, 32'(k)};
   endfunction

   function automatic logic [63:0] trl(input int g, input int c, input int s);
      return {16'hDB60, 4'h0, 4'(g), 8'(c), 32'(s)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push_burst(input int g, input int start, input int n, input int s);
      for (int j = 0; j < n; j++) exp_q.push_back(mk_word(g, start + j));
      exp_q.push_back(trl(g, n, s));
   endtask

   task automatic cmp_logs(input string name);
      chk({name, "_len"}, 64'(wr_log.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k < wr_log.size()) chk($sformatf("%s[%0d]", name, k), wr_log[k], exp_q[k]);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         src_left[i] = 0;
         src_sent[i] = 0;
      end
      wr_log.delete();
      exp_q.delete();
   endtask

   task automatic rst_pulse();
      @(negedge wr_clk);
      #3;
      rstn = 1'b0;
      #1;
      chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
      chk("rst_din", fifo_din, 64'd0);
      chk("rst_ready", 64'(src_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      chk("rst_seq", 64'(seq_num), 64'd0);
      @(negedge wr_clk);
      rstn = 1'b1;
   endtask

   // One cycle with the behavioural sources; logs every FIFO write.
   task automatic tick(input logic t_en, input logic t_full, input logic t_pf);
      logic [N-1:0] xfer;
      @(negedge wr_clk);
      en             = t_en;
      fifo_full      = t_full;
      fifo_prog_full = t_pf;
      for (int i = 0; i < N; i++) begin
         src_valid[i]         = (src_left[i] != 0);
         src_data[64*i +: 64] = mk_word(i, src_sent[i]);
      end
      #2;
      if (fifo_wr_en) wr_log.push_back(fifo_din);
      else chk("din_zero_when_idle", fifo_din, 64'd0);
      if (t_full) begin
         chk("full_wr_en", 64'(fifo_wr_en), 64'd0);
         chk("full_ready", 64'(src_ready), 64'd0);
      end
      smp_busy = busy;
      xfer     = src_valid & src_ready;
      @(posedge wr_clk);
      for (int i = 0; i < N; i++) begin
         if (xfer[i]) begin
            src_left[i]--;
            src_sent[i]++;
         end
      end
   endtask

   task automatic gate_scn(input bit use_en, input string nm);
      logic busy_bad;
      logic blk;
      clear_model();
      rst_pulse();
      busy_bad    = 1'b0;
      src_left[2] = 6;
      src_left[3] = 3;
      push_burst(2, 0, 6, 0);
      for (int c = 0; c < 25; c++) begin
         blk = (c >= 3);
         tick(use_en ? !blk : 1'b1, 1'b0, use_en ? 1'b0 : blk);
         if (c >= 10 && smp_busy) busy_bad = 1'b1;
      end
      cmp_logs(nm);
      chk({nm, "_busy_held_idle"}, 64'(busy_bad), 64'd0);
      chk({nm, "_src3_waiting"}, 64'(src_left[3]), 64'd3);
      push_burst(3, 0, 3, 1);
      for (int c = 0; c < 40 && wr_log.size() < exp_q.size(); c++) tick(1'b1, 1'b0, 1'b0);
      cmp_logs({nm, "_resume"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int fcnt;
      logic f;
      logic [63:0] first_w;

      rstn = 1'b0; en = 1'b0; fifo_full = 1'b0; fifo_prog_full = 1'b0;
      src_valid = '0; src_data = '0;
      clear_model();
      #12;
      chk("reset_wr_en", 64'(fifo_wr_en), 64'd0);
      chk("reset_din", fifo_din, 64'd0);
      chk("reset_ready", 64'(src_ready), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_grant", 64'(grant_id), 64'd0);
      chk("reset_seq", 64'(seq_num), 64'd0);
      @(negedge wr_clk);
      rstn = 1'b1;

      //          en    pf    full  v0    d0      we    din     rdy    busy  seq
      vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, W_A,   1'b0, 64'd0,  4'd0, 1'b0, 32'd0};
      vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, W_A,   1'b0, 64'd0,  4'd0, 1'b0, 32'd0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, W_A,   1'b0, 64'd0,  4'd0, 1'b0, 32'd0};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, W_A,   1'b0, 64'd0,  4'd0, 1'b0, 32'd0};
      vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, W_A,   1'b1, W_A,    4'd1, 1'b1, 32'd0};
      vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, W_B,   1'b1, W_B,    4'd1, 1'b1, 32'd0};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, W_C,   1'b1, W_C,    4'd1, 1'b1, 32'd0};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, W_C,   1'b0, 64'd0,  4'd1, 1'b1, 32'd0};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, T_1,    4'd0, 1'b1, 32'd0};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0,  4'd0, 1'b0, 32'd1};
      vt[10] = '{1'b1, 1'b0, 1'b1, 1'b1, W_D,   1'b0, 64'd0,  4'd0, 1'b0, 32'd1};
      vt[11] = '{1'b1, 1'b0, 1'b1, 1'b1, W_D,   1'b0, 64'd0,  4'd0, 1'b1, 32'd1};
      vt[12] = '{1'b1, 1'b0, 1'b0, 1'b1, W_D,   1'b1, W_D,    4'd1, 1'b1, 32'd1};
      vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, W_D,   1'b0, 64'd0,  4'd1, 1'b1, 32'd1};
      vt[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, T_2,    4'd0, 1'b1, 32'd1};
      vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0,  4'd0, 1'b0, 32'd2};

      for (int k = 0; k < 16; k++) begin
         @(negedge wr_clk);
         en             = vt[k].en;
         fifo_prog_full = vt[k].pf;
         fifo_full      = vt[k].full;
         src_valid      = {3'b000, vt[k].v0};
         src_data       = {192'd0, vt[k].d0};
         #2;
         chk($sformatf("vec%0d_wr_en", k), 64'(fifo_wr_en), 64'(vt[k].we));
         chk($sformatf("vec%0d_din", k), fifo_din, vt[k].din);
         chk($sformatf("vec%0d_ready", k), 64'(src_ready), 64'(vt[k].rdy));
         chk($sformatf("vec%0d_busy", k), 64'(busy), 64'(vt[k].busy));
         chk($sformatf("vec%0d_seq", k), 64'(seq_num), 64'(vt[k].seq));
      end

      // Burst cap: 40 words from source 1 split 16/16/8.
      clear_model();
      rst_pulse();
      src_left[1] = 40;
      push_burst(1, 0, 16, 0);
      push_burst(1, 16, 16, 1);
      push_burst(1, 32, 8, 2);
      for (int c = 0; c < 200 && wr_log.size() < exp_q.size(); c++) tick(1'b1, 1'b0, 1'b0);
      #2;
      cmp_logs("cap");
      chk("cap_seq", 64'(seq_num), 64'd3);

      // Fairness: all sources busy, grants rotate 0,1,2,3 twice.
      clear_model();
      rst_pulse();
      for (int i = 0; i < N; i++) src_left[i] = 20;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) push_burst(i, r * 16, (r == 0) ? 16 : 4, r * 4 + i);
      end
      for (int c = 0; c < 400 && wr_log.size() < exp_q.size(); c++) tick(1'b1, 1'b0, 1'b0);
      cmp_logs("fair");

      // Backpressure mid-burst and across the trailer.
      clear_model();
      rst_pulse();
      src_left[0] = 8;
      fcnt = 0;
      push_burst(0, 0, 8, 0);
      for (int c = 0; c < 100 && wr_log.size() < exp_q.size(); c++) begin
         f = (c >= 3 && c < 8) || (src_left[0] == 0 && fcnt < 5);
         if (src_left[0] == 0 && fcnt < 5) fcnt++;
         tick(1'b1, f, 1'b0);
      end
      cmp_logs("bp");

      gate_scn(1'b0, "pfull");
      gate_scn(1'b1, "en");

      // Reset in the middle of a burst owned by source 3.
      clear_model();
      rst_pulse();
      src_left[2] = 2;
      for (int c = 0; c < 30 && wr_log.size() < 3; c++) tick(1'b1, 1'b0, 1'b0);
      src_left[0] = 10;
      src_left[3] = 10;
      for (int c = 0; c < 4; c++) tick(1'b1, 1'b0, 1'b0);
      #2;
      chk("pre_rst_grant", 64'(grant_id), 64'd3);
      chk("pre_rst_seq", 64'(seq_num), 64'd1);
      rst_pulse();
      wr_log.delete();
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      #2;
      first_w = (wr_log.size() > 0) ? wr_log[0] : 64'd0;
      chk("post_rst_first_word", first_w, mk_word(0, 0));
      chk("post_rst_grant", 64'(grant_id), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
